// File: rtl/instr_decode_pkg.sv
// Shared decode definitions for the ID stage: opcode/funct values, ALU control
// codes, the decoded-control bundle and the ID/EX register layout.
package instr_decode_pkg;

    localparam int XLEN   = 32;
    localparam int NREGS  = 32;
    localparam int RIDX_W = $clog2(NREGS);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [2:0] {
        ALU_AND = 3'b000,
        ALU_OR  = 3'b001,
        ALU_ADD = 3'b010,
        ALU_SUB = 3'b110,
        ALU_SLT = 3'b111
    } alu_ctrl_e;

    typedef enum logic [1:0] {
        EXT_SIGN  = 2'd0,
        EXT_ZERO  = 2'd1,
        EXT_UPPER = 2'd2
    } ext_e;

    typedef struct packed {
        logic      valid;
        logic      illegal;
        logic      reg_write;
        logic      mem_to_reg;
        logic      mem_write;
        logic      alu_src;
        alu_ctrl_e alu_ctrl;
        ext_e      ext_sel;
        logic      reg_dst;
        logic      zero_a;
        logic      branch_eq;
        logic      branch_ne;
        logic      jump;
    } ctrl_t;

    typedef struct packed {
        logic              reg_write;
        logic              mem_to_reg;
        logic              mem_write;
        logic              alu_src;
        alu_ctrl_e         alu_ctrl;
        logic [XLEN-1:0]   rd1;
        logic [XLEN-1:0]   rd2;
        logic [XLEN-1:0]   imm;
        logic [RIDX_W-1:0] write_reg;
        logic              illegal;
    } id_ex_t;

    // valid=0 means the instruction becomes a bubble; the all-zero word (sll nop)
    // is a legal bubble, any other unsupported encoding is flagged illegal.
    function automatic ctrl_t decode_ctrl(input logic [XLEN-1:0] instr);
        ctrl_t      c;
        logic [5:0] op;
        logic [5:0] funct;
        op    = instr[31:26];
        funct = instr[5:0];
        c          = '0;
        c.valid    = 1'b1;
        c.alu_ctrl = ALU_ADD;
        c.ext_sel  = EXT_SIGN;
        case (op)
            OP_RTYPE: begin
                c.reg_write = 1'b1;
                c.reg_dst   = 1'b1;
                case (funct)
                    FN_ADD:  c.alu_ctrl = ALU_ADD;
                    FN_SUB:  c.alu_ctrl = ALU_SUB;
                    FN_AND:  c.alu_ctrl = ALU_AND;
                    FN_OR:   c.alu_ctrl = ALU_OR;
                    FN_SLT:  c.alu_ctrl = ALU_SLT;
                    default: begin
                        c         = '0;
                        c.illegal = (instr != '0);
                    end
                endcase
            end
            OP_LW: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
                c.alu_src    = 1'b1;
            end
            OP_SW: begin
                c.mem_write = 1'b1;
                c.alu_src   = 1'b1;
            end
            OP_BEQ: begin
                c.branch_eq = 1'b1;
                c.alu_ctrl  = ALU_SUB;
            end
            OP_BNE: begin
                c.branch_ne = 1'b1;
                c.alu_ctrl  = ALU_SUB;
            end
            OP_ADDI: begin
                c.reg_write = 1'b1;
                c.alu_src   = 1'b1;
            end
            OP_SLTI: begin
                c.reg_write = 1'b1;
                c.alu_src   = 1'b1;
                c.alu_ctrl  = ALU_SLT;
            end
            OP_ANDI: begin
                c.reg_write = 1'b1;
                c.alu_src   = 1'b1;
                c.alu_ctrl  = ALU_AND;
                c.ext_sel   = EXT_ZERO;
            end
            OP_ORI: begin
                c.reg_write = 1'b1;
                c.alu_src   = 1'b1;
                c.alu_ctrl  = ALU_OR;
                c.ext_sel   = EXT_ZERO;
            end
            OP_LUI: begin
                c.reg_write = 1'b1;
                c.alu_src   = 1'b1;
                c.ext_sel   = EXT_UPPER;
                c.zero_a    = 1'b1;
            end
            OP_J: begin
                c.jump = 1'b1;
            end
            default: begin
                c         = '0;
                c.illegal = 1'b1;
            end
        endcase
        return c;
    endfunction

endpackage

// File: rtl/instr_decode_if.sv
// IF/ID inputs, WB write-back port, next-PC outputs and the ID/EX register
// outputs of the decode stage, bundled as one interface.
interface instr_decode_if;
    import instr_decode_pkg::*;

    logic [XLEN-1:0]   if_id_pc_plus_4;
    logic [XLEN-1:0]   if_id_instr;
    logic              wb_reg_write;
    logic [RIDX_W-1:0] wb_write_reg;
    logic [XLEN-1:0]   wb_result;

    logic              pc_src;
    logic [XLEN-1:0]   pc_branch;
    logic              jump;
    logic [XLEN-1:0]   pc_jump;

    logic              id_ex_reg_write;
    logic              id_ex_mem_to_reg;
    logic              id_ex_mem_write;
    logic              id_ex_alu_src;
    logic [2:0]        id_ex_alu_ctrl;
    logic [XLEN-1:0]   id_ex_rd1;
    logic [XLEN-1:0]   id_ex_rd2;
    logic [XLEN-1:0]   id_ex_imm;
    logic [RIDX_W-1:0] id_ex_write_reg;
    logic              id_ex_illegal;

    modport master (
        output if_id_pc_plus_4, if_id_instr, wb_reg_write, wb_write_reg, wb_result,
        input  pc_src, pc_branch, jump, pc_jump,
        input  id_ex_reg_write, id_ex_mem_to_reg, id_ex_mem_write, id_ex_alu_src,
        input  id_ex_alu_ctrl, id_ex_rd1, id_ex_rd2, id_ex_imm, id_ex_write_reg,
        input  id_ex_illegal
    );

    modport slave (
        input  if_id_pc_plus_4, if_id_instr, wb_reg_write, wb_write_reg, wb_result,
        output pc_src, pc_branch, jump, pc_jump,
        output id_ex_reg_write, id_ex_mem_to_reg, id_ex_mem_write, id_ex_alu_src,
        output id_ex_alu_ctrl, id_ex_rd1, id_ex_rd2, id_ex_imm, id_ex_write_reg,
        output id_ex_illegal
    );

endinterface

// File: rtl/instr_decode_reg_file.sv
// 2-read/1-write register file: $0 hard-wired to zero, write-through bypass
// from WB to both read ports, and synchronous clear of every entry on reset.
module instr_decode_reg_file
    import instr_decode_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [RIDX_W-1:0] ra1,
    input  logic [RIDX_W-1:0] ra2,
    output logic [XLEN-1:0]   rd1,
    output logic [XLEN-1:0]   rd2,
    input  logic              we,
    input  logic [RIDX_W-1:0] wa,
    input  logic [XLEN-1:0]   wd
);

    logic [XLEN-1:0] regs_reg [NREGS];
    logic            wr_en;

    assign wr_en = we && !reset && (wa != '0);

    generate
        for (genvar gi = 0; gi < NREGS; gi++) begin : g_reg
            always_ff @(posedge clk) begin
                if (reset) begin
                    regs_reg[gi] <= '0;
                end else if (wr_en && (wa == RIDX_W'(gi))) begin
                    regs_reg[gi] <= wd;
                end
            end
        end
    endgenerate

    // A read of the register WB writes this cycle sees the new value, so a
    // producer three instructions ahead needs no extra NOP.
    always_comb begin
        rd1 = '0;
        rd2 = '0;
        if (ra1 != '0) begin
            rd1 = (wr_en && (wa == ra1)) ? wd : regs_reg[ra1];
        end
        if (ra2 != '0) begin
            rd2 = (wr_en && (wa == ra2)) ? wd : regs_reg[ra2];
        end
    end

endmodule

// File: rtl/instr_decode.sv
// MIPS ID stage: decode, register read, branch/jump resolution in ID, and the
// ID/EX pipeline register. The instruction in IF is the delay slot.
module instr_decode
    import instr_decode_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    instr_decode_if.slave  bus
);

    logic [XLEN-1:0]   instr;
    logic [RIDX_W-1:0] rs;
    logic [RIDX_W-1:0] rt;
    logic [RIDX_W-1:0] rd;
    logic [15:0]       imm16;
    ctrl_t             ctrl;
    logic [XLEN-1:0]   rs_val;
    logic [XLEN-1:0]   rt_val;
    logic [XLEN-1:0]   imm_ext;
    logic [XLEN-1:0]   branch_off;
    logic              regs_equal;
    id_ex_t            id_ex_reg;
    id_ex_t            id_ex_next;

    assign instr = bus.if_id_instr;
    assign rs    = instr[25:21];
    assign rt    = instr[20:16];
    assign rd    = instr[15:11];
    assign imm16 = instr[15:0];
    assign ctrl  = decode_ctrl(instr);

    instr_decode_reg_file u_reg_file (
        .clk   (clk),
        .reset (reset),
        .ra1   (rs),
        .ra2   (rt),
        .rd1   (rs_val),
        .rd2   (rt_val),
        .we    (bus.wb_reg_write),
        .wa    (bus.wb_write_reg),
        .wd    (bus.wb_result)
    );

    always_comb begin
        case (ctrl.ext_sel)
            EXT_ZERO:  imm_ext = {16'h0000, imm16};
            EXT_UPPER: imm_ext = {imm16, 16'h0000};
            default:   imm_ext = {{16{imm16[15]}}, imm16};
        endcase
    end

    // Branch target and compare use the bypassed operands.
    assign branch_off    = {{14{imm16[15]}}, imm16, 2'b00};
    assign regs_equal    = (rs_val == rt_val);
    assign bus.pc_branch = bus.if_id_pc_plus_4 + branch_off;
    assign bus.pc_src    = !reset && ((ctrl.branch_eq && regs_equal) ||
                                      (ctrl.branch_ne && !regs_equal));
    assign bus.pc_jump   = {bus.if_id_pc_plus_4[31:28], instr[25:0], 2'b00};
    assign bus.jump      = !reset && ctrl.jump;

    always_comb begin
        id_ex_next         = '0;
        id_ex_next.illegal = ctrl.illegal;
        if (ctrl.valid) begin
            id_ex_next.reg_write  = ctrl.reg_write;
            id_ex_next.mem_to_reg = ctrl.mem_to_reg;
            id_ex_next.mem_write  = ctrl.mem_write;
            id_ex_next.alu_src    = ctrl.alu_src;
            id_ex_next.alu_ctrl   = ctrl.alu_ctrl;
            id_ex_next.rd1        = ctrl.zero_a ? '0 : rs_val;
            id_ex_next.rd2        = rt_val;
            id_ex_next.imm        = imm_ext;
            id_ex_next.write_reg  = ctrl.reg_dst ? rd : rt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            id_ex_reg <= '0;
        end else begin
            id_ex_reg <= id_ex_next;
        end
    end

    assign bus.id_ex_reg_write  = id_ex_reg.reg_write;
    assign bus.id_ex_mem_to_reg = id_ex_reg.mem_to_reg;
    assign bus.id_ex_mem_write  = id_ex_reg.mem_write;
    assign bus.id_ex_alu_src    = id_ex_reg.alu_src;
    assign bus.id_ex_alu_ctrl   = id_ex_reg.alu_ctrl;
    assign bus.id_ex_rd1        = id_ex_reg.rd1;
    assign bus.id_ex_rd2        = id_ex_reg.rd2;
    assign bus.id_ex_imm        = id_ex_reg.imm;
    assign bus.id_ex_write_reg  = id_ex_reg.write_reg;
    assign bus.id_ex_illegal    = id_ex_reg.illegal;

endmodule

// File: tb/tb_instr_decode.sv
// Self-checking bench for instr_decode: next-PC outputs checked inline, ID/EX
// contents checked through a scoreboard of hand-computed expected words.
module tb_instr_decode;
    import instr_decode_pkg::*;

    typedef logic [108:0] idex_t;

    logic  clk;
    logic  reset;
    int    total;
    int    bad;
    idex_t sb[$];
    idex_t exp_w;
    idex_t got_w;

    instr_decode_if bus();

    instr_decode dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    function automatic idex_t mk(input logic rw, input logic m2r, input logic mw, input logic as,
                                 input logic [2:0] ctl, input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] imm, input logic [4:0] wr, input logic ill);
        return {rw, m2r, mw, as, ctl, a, b, imm, wr, ill};
    endfunction

    function automatic idex_t got_idex();
        return {bus.id_ex_reg_write, bus.id_ex_mem_to_reg, bus.id_ex_mem_write, bus.id_ex_alu_src,
                bus.id_ex_alu_ctrl, bus.id_ex_rd1, bus.id_ex_rd2, bus.id_ex_imm,
                bus.id_ex_write_reg, bus.id_ex_illegal};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'd0, fn};
    endfunction

    task automatic drive(input logic [31:0] pc4, input logic [31:0] ins, input logic wbe,
                         input logic [4:0] wr, input logic [31:0] wd);
        bus.if_id_pc_plus_4 = pc4;
        bus.if_id_instr     = ins;
        bus.wb_reg_write    = wbe;
        bus.wb_write_reg    = wr;
        bus.wb_result       = wd;
        $display("txn pc4=%h instr=%h wb=%0b r%0d<=%h reset=%0b", pc4, ins, wbe, wr, wd, reset);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        drive(32'h40, enc_i(6'h04, 5'd0, 5'd0, 16'h0001), 1'b1, 5'd5, 32'h55);
        @(negedge clk);
        total++;
        if (bus.pc_src !== 1'b0) begin bad++; $display("FAIL reset_pc_src got=%b exp=0", bus.pc_src); end
        tick();
        drive(32'h80000004, 32'h08000010, 1'b1, 5'd5, 32'h55);
        @(negedge clk);
        total++;
        if (bus.jump !== 1'b0) begin bad++; $display("FAIL reset_jump got=%b exp=0", bus.jump); end
        tick();
        got_w = got_idex();
        total++;
        if (got_w !== '0) begin bad++; $display("FAIL reset_idex got=%h exp=0", got_w); end
        reset = 1'b0;
        drive(32'h0, enc_i(6'h08, 5'd5, 5'd6, 16'h0000), 1'b0, 5'd0, 32'h0);
        sb.push_back(mk(1, 0, 0, 1, 3'b010, 32'h0, 32'h0, 32'h0, 5'd6, 0));
        tick();
        exp_w = sb.pop_front(); got_w = got_idex(); total++;
        if (got_w !== exp_w) begin bad++; $display("FAIL reset_regs_clear got=%h exp=%h", got_w, exp_w); end
    endtask

    task automatic test_beq();
        drive(32'h0, 32'h0, 1'b1, 5'd8, 32'd5);
        sb.push_back('0);
        tick();
        exp_w = sb.pop_front(); got_w = got_idex(); total++;
        if (got_w !== exp_w) begin bad++; $display("FAIL nop_idex got=%h exp=%h", got_w, exp_w); end
        drive(32'h0, 32'h0, 1'b1, 5'd9, 32'd5);
        sb.push_back('0);
        tick();
        exp_w = sb.pop_front(); got_w = got_idex(); total++;
        if (got_w !== exp_w) begin bad++; $display("FAIL nop_idex2 got=%h exp=%h", got_w, exp_w); end
        drive(32'h40, enc_i(6'h04, 5'd8, 5'd9, 16'h0003), 1'b0, 5'd0, 32'h0);
        sb.push_back(mk(0, 0, 0, 0, 3'b110, 32'd5, 32'd5, 32'd3, 5'd9, 0));
        @(negedge clk);
        total++;
        if (bus.pc_src !== 1'b1) begin bad++; $display("FAIL beq_pc_src got=%b exp=1", bus.pc_src); end
        total++;
        if (bus.pc_branch !== 32'h4C) begin bad++; $display("FAIL beq_target got=%h exp=0000004c", bus.pc_branch); end
        total++;
        if (bus.jump !== 1'b0) begin bad++; $display("FAIL beq_jump got=%b exp=0", bus.jump); end
        tick();
        exp_w = sb.pop_front(); got_w = got_idex(); total++;
        if (got_w !== exp_w) begin bad++; $display("FAIL beq_idex got=%h exp=%h", got_w, exp_w); end
        drive(32'h40, enc_i(6'h05, 5'd8, 5'd9, 16'h0003), 1'b0, 5'd0, 32'h0);
        sb.push_back(mk(0, 0, 0, 0, 3'b110, 32'd5, 32'd5, 32'd3, 5'd9, 0));
        @(negedge clk);
        total++;
        if (bus.pc_src !== 1'b0) begin bad++; $display("FAIL bne_not_taken got=%b exp=0", bus.pc_src); end
        tick();
        exp_w = sb.pop_front(); got_w = got_idex(); total++;
        if (got_w !== exp_w) begin bad++; $display("FAIL bne_nt_idex got=%h exp=%h", got_w, exp_w); end
    endtask

    task automatic test_bne_bypass();
        drive(32'h40, enc_i(6'h05, 5'd8, 5'd9, 16'hFFFF), 1'b1, 5'd9, 32'd6);
        sb.push_back(mk(0, 0, 0, 0, 3'b110, 32'd5, 32'd6, 32'hFFFFFFFF, 5'd9, 0));
        @(negedge clk);
        total++;
        if (bus.pc_src !== 1'b1) begin bad++; $display("FAIL bne_bypass_pc_src got=%b exp=1", bus.pc_src); end
        total++;
        if (bus.pc_branch !== 32'h3C) begin bad++; $display("FAIL bne_target got=%h exp=0000003c", bus.pc_branch); end
        tick();
        exp_w = sb.pop_front(); got_w = got_idex(); total++;
        if (got_w !== exp_w) begin bad++; $display("FAIL bne_bypass_idex got=%h exp=%h", got_w, exp_w); end
        drive(32'hFFFFFFFC, enc_i(6'h05, 5'd8, 5'd9, 16'h0002), 1'b0, 5'd0, 32'h0);
        sb.push_back(mk(0, 0, 0, 0, 3'b110, 32'd5, 32'd6, 32'd2, 5'd9, 0));
        @(negedge clk);
        total++;
        if (bus.pc_branch !== 32'h4) begin bad++; $display("FAIL branch_wrap got=%h exp=00000004", bus.pc_branch); end
        total++;
        if (bus.pc_src !== 1'b1) begin bad++; $display("FAIL bne_wrap_pc_src got=%b exp=1", bus.pc_src); end
        tick();
        exp_w = sb.pop_front(); got_w = got_idex(); total++;
        if (got_w !== exp_w) begin bad++; $display("FAIL bne_wrap_idex got=%h exp=%h", got_w, exp_w); end
        drive(32'h100, enc_i(6'h04, 5'd8, 5'd9, 16'h8000), 1'b1, 5'd8, 32'd6);
        sb.push_back(mk(0, 0, 0, 0, 3'b110, 32'd6, 32'd6, 32'hFFFF8000, 5'd9, 0));
        @(negedge clk);
        total++;
        if (bus.pc_src !== 1'b1) begin bad++; $display("FAIL beq_bypass_rs got=%b exp=1", bus.pc_src); end
        total++;
        if (bus.pc_branch !== 32'hFFFE0100) begin bad++; $display("FAIL beq_min_off got=%h exp=fffe0100", bus.pc_branch); end
        tick();
        exp_w = sb.pop_front(); got_w = got_idex(); total++;
        if (got_w !== exp_w) begin bad++; $display("FAIL beq_bypass_idex got=%h exp=%h", got_w, exp_w); end
        drive(32'h0, 32'h0, 1'b1, 5'd8, 32'd5);
        sb.push_back('0);
        tick();
        exp_w = sb.pop_front(); got_w = got_idex(); total++;
        if (got_w !== exp_w) begin bad++; $display("FAIL nop_idex3 got=%h exp=%h", got_w, exp_w); end
    endtask

    task automatic test_jump();
        drive(32'h80000004, 32'h08000010, 1'b0, 5'd0, 32'h0);
        @(negedge clk);
        total++;
        if (bus.jump !== 1'b1) begin bad++; $display("FAIL j_jump got=%b exp=1", bus.jump); end
        total++;
        if (bus.pc_jump !== 32'h80000040) begin bad++; $display("FAIL j_target got=%h exp=80000040", bus.pc_jump); end
        total++;
        if (bus.pc_src !== 1'b0) begin bad++; $display("FAIL j_pc_src got=%b exp=0", bus.pc_src); end
        tick();
        total++;
        if (bus.id_ex_reg_write !== 1'b0) begin bad++; $display("FAIL j_reg_write got=%b exp=0", bus.id_ex_reg_write); end
        drive(32'h7FFFFFFC, 32'h0BFFFFFF, 1'b0, 5'd0, 32'h0);
        @(negedge clk);
        total++;
        if (bus.pc_jump !== 32'h7FFFFFFC) begin bad++; $display("FAIL j_target_max got=%h exp=7ffffffc", bus.pc_jump); end
        tick();
        total++;
        if (bus.id_ex_mem_write !== 1'b0) begin bad++; $display("FAIL j_mem_write got=%b exp=0", bus.id_ex_mem_write); end
    endtask

    // Back-to-back issue: one instruction per cycle, each checked the cycle after.
    task automatic test_back_to_back();
        logic [31:0] ins [11];
        idex_t       ex  [11];
        ins[0]  = enc_i(6'h08, 5'd8, 5'd10, 16'hFFFF);
        ex[0]   = mk(1, 0, 0, 1, 3'b010, 32'd5, 32'd0, 32'hFFFFFFFF, 5'd10, 0);
        ins[1]  = enc_r(5'd8, 5'd9, 5'd11, 6'h20);
        ex[1]   = mk(1, 0, 0, 0, 3'b010, 32'd5, 32'd6, 32'h5820, 5'd11, 0);
        ins[2]  = enc_r(5'd8, 5'd9, 5'd11, 6'h22);
        ex[2]   = mk(1, 0, 0, 0, 3'b110, 32'd5, 32'd6, 32'h5822, 5'd11, 0);
        ins[3]  = enc_r(5'd8, 5'd9, 5'd11, 6'h24);
        ex[3]   = mk(1, 0, 0, 0, 3'b000, 32'd5, 32'd6, 32'h5824, 5'd11, 0);
        ins[4]  = enc_r(5'd8, 5'd9, 5'd11, 6'h25);
        ex[4]   = mk(1, 0, 0, 0, 3'b001, 32'd5, 32'd6, 32'h5825, 5'd11, 0);
        ins[5]  = enc_r(5'd8, 5'd9, 5'd11, 6'h2A);
        ex[5]   = mk(1, 0, 0, 0, 3'b111, 32'd5, 32'd6, 32'h582A, 5'd11, 0);
        ins[6]  = enc_i(6'h23, 5'd8, 5'd12, 16'hFFF8);
        ex[6]   = mk(1, 1, 0, 1, 3'b010, 32'd5, 32'd0, 32'hFFFFFFF8, 5'd12, 0);
        ins[7]  = enc_i(6'h2B, 5'd8, 5'd9, 16'h0004);
        ex[7]   = mk(0, 0, 1, 1, 3'b010, 32'd5, 32'd6, 32'd4, 5'd9, 0);
        ins[8]  = enc_i(6'h0A, 5'd8, 5'd13, 16'h8000);
        ex[8]   = mk(1, 0, 0, 1, 3'b111, 32'd5, 32'd0, 32'hFFFF8000, 5'd13, 0);
        ins[9]  = enc_i(6'h0C, 5'd8, 5'd13, 16'h8001);
        ex[9]   = mk(1, 0, 0, 1, 3'b000, 32'd5, 32'd0, 32'h00008001, 5'd13, 0);
        ins[10] = enc_i(6'h0D, 5'd9, 5'd13, 16'hFFFF);
        ex[10]  = mk(1, 0, 0, 1, 3'b001, 32'd6, 32'd0, 32'h0000FFFF, 5'd13, 0);
        for (int i = 0; i < 11; i++) begin
            drive(32'h200, ins[i], 1'b0, 5'd0, 32'h0);
            sb.push_back(ex[i]);
            tick();
            exp_w = sb.pop_front(); got_w = got_idex(); total++;
            if (got_w !== exp_w) begin bad++; $display("FAIL b2b_%0d got=%h exp=%h", i, got_w, exp_w); end
        end
    endtask

    task automatic test_lui_r0();
        drive(32'h0, enc_i(6'h0F, 5'd8, 5'd1, 16'h1234), 1'b0, 5'd0, 32'h0);
        sb.push_back(mk(1, 0, 0, 1, 3'b010, 32'd0, 32'd0, 32'h12340000, 5'd1, 0));
        tick();
        exp_w = sb.pop_front(); got_w = got_idex(); total++;
        if (got_w !== exp_w) begin bad++; $display("FAIL lui_idex got=%h exp=%h", got_w, exp_w); end
        drive(32'h0, enc_i(6'h08, 5'd0, 5'd2, 16'h0000), 1'b1, 5'd0, 32'd7);
        sb.push_back(mk(1, 0, 0, 1, 3'b010, 32'd0, 32'd0, 32'd0, 5'd2, 0));
        tick();
        exp_w = sb.pop_front(); got_w = got_idex(); total++;
        if (got_w !== exp_w) begin bad++; $display("FAIL r0_no_bypass got=%h exp=%h", got_w, exp_w); end
        drive(32'h0, enc_i(6'h2B, 5'd0, 5'd0, 16'h0000), 1'b0, 5'd0, 32'h0);
        sb.push_back(mk(0, 0, 1, 1, 3'b010, 32'd0, 32'd0, 32'd0, 5'd0, 0));
        tick();
        exp_w = sb.pop_front(); got_w = got_idex(); total++;
        if (got_w !== exp_w) begin bad++; $display("FAIL r0_read_zero got=%h exp=%h", got_w, exp_w); end
    endtask

    task automatic test_illegal();
        logic [31:0] ins [4];
        idex_t       ex  [4];
        ins[0] = enc_i(6'h3F, 5'd8, 5'd9, 16'h1234);  ex[0] = mk(0, 0, 0, 0, 3'b000, 0, 0, 0, 5'd0, 1);
        ins[1] = 32'h0;                                ex[1] = '0;
        ins[2] = enc_r(5'd8, 5'd9, 5'd11, 6'h3F);     ex[2] = mk(0, 0, 0, 0, 3'b000, 0, 0, 0, 5'd0, 1);
        ins[3] = 32'h0C000010;                         ex[3] = mk(0, 0, 0, 0, 3'b000, 0, 0, 0, 5'd0, 1);
        for (int i = 0; i < 4; i++) begin
            drive(32'h40, ins[i], 1'b0, 5'd0, 32'h0);
            sb.push_back(ex[i]);
            @(negedge clk);
            total++;
            if ((bus.pc_src !== 1'b0) || (bus.jump !== 1'b0)) begin
                bad++; $display("FAIL illegal_pc_%0d got=%b%b exp=00", i, bus.pc_src, bus.jump);
            end
            tick();
            exp_w = sb.pop_front(); got_w = got_idex(); total++;
            if (got_w !== exp_w) begin bad++; $display("FAIL illegal_idex_%0d got=%h exp=%h", i, got_w, exp_w); end
        end
    endtask

    task automatic test_reset_mid();
        reset = 1'b1;
        drive(32'h40, enc_i(6'h05, 5'd8, 5'd9, 16'h0003), 1'b1, 5'd8, 32'd9);
        @(negedge clk);
        total++;
        if (bus.pc_src !== 1'b0) begin bad++; $display("FAIL mid_reset_pc_src got=%b exp=0", bus.pc_src); end
        tick();
        got_w = got_idex(); total++;
        if (got_w !== '0) begin bad++; $display("FAIL mid_reset_idex got=%h exp=0", got_w); end
        drive(32'h40, enc_i(6'h08, 5'd8, 5'd10, 16'hFFFF), 1'b1, 5'd9, 32'd9);
        tick();
        got_w = got_idex(); total++;
        if (got_w !== '0) begin bad++; $display("FAIL mid_reset_idex2 got=%h exp=0", got_w); end
        reset = 1'b0;
        drive(32'h40, enc_i(6'h05, 5'd8, 5'd9, 16'h0003), 1'b0, 5'd0, 32'h0);
        sb.push_back(mk(0, 0, 0, 0, 3'b110, 32'd0, 32'd0, 32'd3, 5'd9, 0));
        @(negedge clk);
        total++;
        if (bus.pc_src !== 1'b0) begin bad++; $display("FAIL post_reset_bne got=%b exp=0", bus.pc_src); end
        tick();
        exp_w = sb.pop_front(); got_w = got_idex(); total++;
        if (got_w !== exp_w) begin bad++; $display("FAIL post_reset_bne_idex got=%h exp=%h", got_w, exp_w); end
        drive(32'h44, enc_i(6'h08, 5'd8, 5'd10, 16'hFFFF), 1'b0, 5'd0, 32'h0);
        sb.push_back(mk(1, 0, 0, 1, 3'b010, 32'd0, 32'd0, 32'hFFFFFFFF, 5'd10, 0));
        tick();
        exp_w = sb.pop_front(); got_w = got_idex(); total++;
        if (got_w !== exp_w) begin bad++; $display("FAIL post_reset_addi got=%h exp=%h", got_w, exp_w); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        drive(32'h0, 32'h0, 1'b0, 5'd0, 32'h0);
        test_reset();
        test_beq();
        test_bne_bypass();
        test_jump();
        test_back_to_back();
        test_lui_r0();
        test_illegal();
        test_reset_mid();
        total++;
        if (sb.size() != 0) begin bad++; $display("FAIL scoreboard_drain got=%0d exp=0", sb.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
